upsampler_sample_feeder: RTL and testbench
==========================================

// Module: upsampler_sample_feeder
// PURPOSE
//  CPU-to-DSP sample source for the upconversion path: the CPU (CSR writes) pushes signed
//  16-bit baseband samples into a FIFO; the block pops one per upsampler input strobe and
//  drives the upsampler_input port of the DSP chain. Mirror of the downsampled_data/ce_down
//  CPU readout path. Priming, underrun and overflow are handled here.
// PARAMETERS
//  DW          16   sample width (signed)
//  AW          10   FIFO address width; depth = 2**AW
//  START_LEVEL 512  FIFO level required to leave PRIME (1..2**AW)
// PORTS
//  sys_clk      in   1      system clock (only clock)
//  rst_n        in   1      asynchronous reset, active low
//  wr_en        in   1      CPU write strobe, one sample per cycle high
//  wr_data      in   DW     CPU sample, signed
//  flush        in   1      synchronous FIFO/state clear, one-cycle pulse
//  clr_stats    in   1      synchronous clear of the underrun/overflow counters
//  sample_ce    in   1      sample request from DSP, one-cycle pulse per upsampler input period
//  sample_out   out  DW     signed sample to upsampler_input (registered)
//  sample_valid out  1      1-cycle pulse: sample_out updated this cycle
//  running      out  1      1 = RUN state
//  fifo_level   out  AW+1   current occupancy, 0..2**AW
//  fifo_full    out  1      fifo_level == 2**AW
//  underrun_cnt out  16     saturating count of sample_ce with empty FIFO while RUN
//  overflow_cnt out  16     saturating count of wr_en dropped because full
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers 0, state PRIME, sample_out 0, sample_valid 0,
//    counters 0, fifo_level 0. Reset mid-stream discards all FIFO contents.
//  - FIFO: single-clock, pointers AW+1 bits, wrap naturally modulo 2**(AW+1).
//    Full/empty evaluated on pre-cycle state. Write when full: dropped, overflow_cnt+1,
//    even if a pop occurs the same cycle. Write+pop same cycle (not full, not empty):
//    both happen, level unchanged. Empty + write + sample_ce: no bypass, write accepted,
//    pop treated as empty.
//  - State PRIME: sample_ce ignored for pops; sample_out held at 0; sample_valid pulses
//    on sample_ce. PRIME->RUN when fifo_level >= START_LEVEL (registered, takes effect next cycle).
//  - State RUN: on sample_ce with FIFO non-empty: pop; sample_out <= head, sample_valid=1
//    one cycle after sample_ce (latency 1). With FIFO empty: underrun_cnt+1 (saturates at
//    16'hFFFF), underrun-output rule below applies, state -> PRIME.
//  - flush: pointers 0, state PRIME, sample_out 0 next cycle; counters untouched.
//    flush has priority over same-cycle wr_en and sample_ce (both discarded, not counted).
//  - clr_stats: counters 0 next cycle; if an increment event coincides, clear wins.
//  - No arithmetic on samples; wr_data passed bit-exact.
// CONFIGURATION
//  UNDERRUN_HOLD_EN defined: on underrun sample_out holds the last popped sample
//    (sample_valid still pulses); in PRIME after an underrun the held value is kept
//    until flush/reset.
//  UNDERRUN_HOLD_EN undefined: on underrun and throughout PRIME sample_out is forced to 0.
// TESTING
//  1 Reset: drive rst_n low mid-stream -> all outputs 0, running=0, level=0 immediately.
//  2 Prime: START_LEVEL=4, write 1,2,3 -> running=0; write 4 -> running=1 next cycle;
//    four sample_ce -> sample_out 1,2,3,4 each 1 cycle after ce, sample_valid pulses.
//  3 Underrun: 5th sample_ce on empty -> underrun_cnt=1, running=0, sample_out=0
//    (=4 with UNDERRUN_HOLD_EN).
//  4 Overflow: AW=2, fill 4 samples, write 0x7FFF with simultaneous pop -> write dropped,
//    overflow_cnt=1, level=3.
//  5 Wrap: 3*2**AW write/pop cycles with random sample_ce spacing -> output stream equals
//    input stream, no count changes.
//  6 flush with wr_en+sample_ce same cycle -> level 0, PRIME, counters unchanged.

Source files
------------

// File: rtl/upsampler_sample_feeder_if.sv
// Bus bundle between the CPU/DSP side and upsampler_sample_feeder.
// master = CPU/DSP driver side, slave = the feeder block.
interface upsampler_sample_feeder_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          flush;
    logic          clr_stats;
    logic          sample_ce;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          running;
    logic [AW:0]   fifo_level;
    logic          fifo_full;
    logic [15:0]   underrun_cnt;
    logic [15:0]   overflow_cnt;

    modport master (
        output wr_en, wr_data, flush, clr_stats, sample_ce,
        input  sample_out, sample_valid, running, fifo_level, fifo_full,
               underrun_cnt, overflow_cnt
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_stats, sample_ce,
        output sample_out, sample_valid, running, fifo_level, fifo_full,
               underrun_cnt, overflow_cnt
    );
endinterface

// File: rtl/upsampler_sample_feeder.sv
// CPU-fed sample FIFO that primes to START_LEVEL, then pops one sample per sample_ce.
// Optional feature macro: UNDERRUN_HOLD_EN (hold last popped sample on underrun instead of 0).
module upsampler_sample_feeder #(
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 10,
    parameter int unsigned START_LEVEL = 512
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    upsampler_sample_feeder_if.slave     bus
);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

`ifdef UNDERRUN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            full_q, full_d;
    logic [DW-1:0]   out_q, out_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   unr_q, unr_d;
    logic [CW-1:0]   ovf_q, ovf_d;

    logic            empty_c;
    logic            push_c;
    logic            pop_c;
    logic            unr_evt_c;
    logic            ovf_evt_c;

    logic [DW-1:0]   mem [DEPTH];

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PRIME;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            unr_q    <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            unr_q    <= unr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; contents are meaningless outside the pointer window, so no reset
    always_ff @(posedge sys_clk) begin
        if (push_c) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        end
    end

    // Next-state, FIFO control and output selection
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        unr_evt_c = 1'b0;
        ovf_evt_c = 1'b0;
        empty_c   = (level_q == '0);

        if (bus.flush) begin
            state_d  = ST_PRIME;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            out_d    = '0;
        end else begin
            if (bus.wr_en) begin
                if (full_q) begin
                    ovf_evt_c = 1'b1;
                end else begin
                    push_c = 1'b1;
                end
            end

            unique case (state_q)
                ST_PRIME: begin
                    valid_d = bus.sample_ce;
                    out_d   = HOLD_EN ? out_q : '0;
                    if (level_q >= LW'(START_LEVEL)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.sample_ce) begin
                        valid_d = 1'b1;
                        if (!empty_c) begin
                            pop_c = 1'b1;
                            out_d = mem[rd_ptr_q[AW-1:0]];
                        end else begin
                            unr_evt_c = 1'b1;
                            state_d   = ST_PRIME;
                            out_d     = HOLD_EN ? out_q : '0;
                        end
                    end
                end
                default: state_d = ST_PRIME;
            endcase

            if (push_c) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + LW'(1);
        end

        level_d = bus.flush ? '0 : (level_q + LW'(push_c) - LW'(pop_c));
        full_d  = (level_d == LW'(DEPTH));

        // Clear beats a coincident increment; increments saturate
        if (bus.clr_stats) begin
            unr_d = '0;
            ovf_d = '0;
        end else begin
            unr_d = (unr_evt_c && unr_q != CNT_MAX) ? unr_q + CW'(1) : unr_q;
            ovf_d = (ovf_evt_c && ovf_q != CNT_MAX) ? ovf_q + CW'(1) : ovf_q;
        end
    end

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign bus.running      = (state_q == ST_RUN);
    assign bus.fifo_level   = level_q;
    assign bus.fifo_full    = full_q;
    assign bus.underrun_cnt = unr_q;
    assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_upsampler_sample_feeder.sv
// Directed bench for upsampler_sample_feeder: small FIFO (AW=2), START_LEVEL=4.
module tb_upsampler_sample_feeder;

`ifdef UNDERRUN_HOLD_EN
    localparam logic [15:0] EXP_UNR_OUT = 16'd4;
`else
    localparam logic [15:0] EXP_UNR_OUT = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    upsampler_sample_feeder_if #(.DW(16), .AW(2)) bus ();

    upsampler_sample_feeder #(.DW(16), .AW(2), .START_LEVEL(4)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic ce();
        bus.sample_ce = 1'b1;
        cyc();
        bus.sample_ce = 1'b0;
    endtask

    logic [15:0] q[$];
    logic [15:0] v;

    initial begin
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.flush     = 1'b0;
        bus.clr_stats = 1'b0;
        bus.sample_ce = 1'b0;
        repeat (2) cyc();
        chk("rst_level",   16'(bus.fifo_level), 16'd0);
        chk("rst_out",     bus.sample_out, 16'd0);
        chk("rst_valid",   16'(bus.sample_valid), 16'd0);
        chk("rst_running", 16'(bus.running), 16'd0);
        chk("rst_unr",     bus.underrun_cnt, 16'd0);
        chk("rst_ovf",     bus.overflow_cnt, 16'd0);
        rst_n = 1'b1;
        cyc();

        // PRIME: ce pulses valid but pops nothing
        ce();
        chk("prime_valid", 16'(bus.sample_valid), 16'd1);
        chk("prime_out",   bus.sample_out, 16'd0);
        chk("prime_level", 16'(bus.fifo_level), 16'd0);

        write(16'd1); write(16'd2); write(16'd3);
        chk("prime_lvl3", 16'(bus.fifo_level), 16'd3);
        chk("prime_run0", 16'(bus.running), 16'd0);
        write(16'd4);
        chk("prime_lvl4", 16'(bus.fifo_level), 16'd4);
        chk("prime_full", 16'(bus.fifo_full), 16'd1);
        cyc();
        chk("run_enter", 16'(bus.running), 16'd1);

        for (int k = 1; k <= 4; k++) begin
            ce();
            chk("pop_out",   bus.sample_out, 16'(k));
            chk("pop_valid", 16'(bus.sample_valid), 16'd1);
            chk("pop_level", 16'(bus.fifo_level), 16'(4 - k));
        end
        cyc();
        chk("valid_drop", 16'(bus.sample_valid), 16'd0);

        // Underrun on empty FIFO
        ce();
        chk("unr_cnt",     bus.underrun_cnt, 16'd1);
        chk("unr_running", 16'(bus.running), 16'd0);
        chk("unr_valid",   16'(bus.sample_valid), 16'd1);
        chk("unr_out",     bus.sample_out, EXP_UNR_OUT);

        // Overflow: full FIFO, write plus pop in the same cycle
        write(16'h8001); write(16'h1234); write(16'hFFFE); write(16'h0042);
        cyc();
        chk("ovf_running", 16'(bus.running), 16'd1);
        bus.wr_en     = 1'b1;
        bus.wr_data   = 16'h7FFF;
        bus.sample_ce = 1'b1;
        cyc();
        bus.wr_en     = 1'b0;
        bus.sample_ce = 1'b0;
        chk("ovf_cnt",   bus.overflow_cnt, 16'd1);
        chk("ovf_level", 16'(bus.fifo_level), 16'd3);
        chk("ovf_out",   bus.sample_out, 16'h8001);
        chk("ovf_full",  16'(bus.fifo_full), 16'd0);

        // Pointer wrap with random ce spacing
        q = '{16'h1234, 16'hFFFE, 16'h0042};
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(3, 0)) cyc();
            ce();
            chk("wrap_out", bus.sample_out, q.pop_front());
            v = 16'(16'hA000 + i * 16'h0111);
            write(v);
            q.push_back(v);
        end
        chk("wrap_level",   16'(bus.fifo_level), 16'd3);
        chk("wrap_unr",     bus.underrun_cnt, 16'd1);
        chk("wrap_ovf",     bus.overflow_cnt, 16'd1);
        chk("wrap_running", 16'(bus.running), 16'd1);

        // flush beats coincident write and ce
        bus.flush     = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 16'h5555;
        bus.sample_ce = 1'b1;
        cyc();
        bus.flush     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.sample_ce = 1'b0;
        chk("flush_level",   16'(bus.fifo_level), 16'd0);
        chk("flush_running", 16'(bus.running), 16'd0);
        chk("flush_out",     bus.sample_out, 16'd0);
        chk("flush_valid",   16'(bus.sample_valid), 16'd0);
        chk("flush_unr",     bus.underrun_cnt, 16'd1);
        chk("flush_ovf",     bus.overflow_cnt, 16'd1);

        bus.clr_stats = 1'b1;
        cyc();
        bus.clr_stats = 1'b0;
        chk("clr_unr", bus.underrun_cnt, 16'd0);
        chk("clr_ovf", bus.overflow_cnt, 16'd0);

        // clr_stats wins over a coincident overflow
        write(16'h0A0A); write(16'h0B0B); write(16'h0C0C); write(16'h0D0D);
        bus.clr_stats = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 16'h0E0E;
        cyc();
        bus.clr_stats = 1'b0;
        bus.wr_en     = 1'b0;
        chk("clrwin_ovf",   bus.overflow_cnt, 16'd0);
        chk("clrwin_level", 16'(bus.fifo_level), 16'd4);
        chk("clrwin_run",   16'(bus.running), 16'd1);

        ce();
        chk("pre_rst_out", bus.sample_out, 16'h0A0A);
        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level",   16'(bus.fifo_level), 16'd0);
        chk("arst_running", 16'(bus.running), 16'd0);
        chk("arst_out",     bus.sample_out, 16'd0);
        chk("arst_full",    16'(bus.fifo_full), 16'd0);
        chk("arst_valid",   16'(bus.sample_valid), 16'd0);
        rst_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
